// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: drives the PLL reset, retries on lock timeout and
// holds the system reset until lock has been stable for a programmed time.
//
// Ports:
//   refclk      free-running reference clock (sole clock)
//   rst         synchronous active-high reset
//   pll_locked  raw PLL lock flag (asynchronous, may glitch)
//   pll_rst     reset to the PLL, active-high
//   sys_rst     system reset request, active-high (== ~ready)
//   ready       high while locked and released
//   lock_lost   one-cycle pulse when lock drops while running
//   fault       sticky; PLL never locked after all retries
//   retry_cnt   retries consumed in the current acquisition
module pll_lock_supervisor #(
    parameter int SYNC_STAGES         = 2,
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int LOCK_STABLE_CYCLES  = 1000,
    parameter int MAX_RETRIES         = 3,
    parameter int CNT_W               = 16,
    parameter int RETRY_W             = 2
) (
    input  logic               refclk,
    input  logic               rst,
    input  logic               pll_locked,
    output logic               pll_rst,
    output logic               sys_rst,
    output logic               ready,
    output logic               lock_lost,
    output logic               fault,
    output logic [RETRY_W-1:0] retry_cnt
);

    typedef enum logic [2:0] {
        S_PLL_RESET,
        S_WAIT_LOCK,
        S_STABILIZE,
        S_RUN,
        S_FAULT
    } state_t;

    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] ST_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RET_MAX = RETRY_W'(MAX_RETRIES);

    logic [SYNC_STAGES-1:0] r_sync;
    state_t                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [RETRY_W-1:0]     r_retry;

    state_t             w_state_nxt;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [RETRY_W-1:0] w_retry_nxt;
    logic               w_lost_nxt;
    logic               w_locked_s;

    assign w_locked_s = r_sync[SYNC_STAGES-1];

    // Saturating increment so a long dwell can never wrap to a false match.
    assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = w_cnt_inc;
        w_retry_nxt = r_retry;
        w_lost_nxt  = 1'b0;
        unique case (r_state)
            S_PLL_RESET: begin
                if (r_cnt == RST_LAST) w_state_nxt = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                // Lock wins over a coincident timeout.
                if (w_locked_s) begin
                    w_state_nxt = S_STABILIZE;
                end else if (r_cnt == TO_LAST) begin
                    if (r_retry == RET_MAX) begin
                        w_state_nxt = S_FAULT;
                    end else begin
                        w_retry_nxt = r_retry + 1'b1;
                        w_state_nxt = S_PLL_RESET;
                    end
                end
            end
            S_STABILIZE: begin
                if (!w_locked_s) begin
                    w_state_nxt = S_WAIT_LOCK;
                end else if (r_cnt == ST_LAST) begin
                    w_state_nxt = S_RUN;
                    w_retry_nxt = '0;
                end
            end
            S_RUN: begin
                w_cnt_nxt = '0;
                if (!w_locked_s) begin
                    w_state_nxt = S_PLL_RESET;
                    w_lost_nxt  = 1'b1;
                end
            end
            S_FAULT: begin
                w_cnt_nxt = '0;
            end
            default: begin
                w_state_nxt = S_PLL_RESET;
            end
        endcase
        if (w_state_nxt != r_state) w_cnt_nxt = '0;
    end

    // Outputs are decoded from the next state so they move with it.
    always_ff @(posedge refclk) begin
        if (rst) begin
            r_sync    <= '0;
            r_state   <= S_PLL_RESET;
            r_cnt     <= '0;
            r_retry   <= '0;
            pll_rst   <= 1'b1;
            sys_rst   <= 1'b1;
            ready     <= 1'b0;
            lock_lost <= 1'b0;
            fault     <= 1'b0;
        end else begin
            r_sync    <= {r_sync[SYNC_STAGES-2:0], pll_locked};
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_retry   <= w_retry_nxt;
            pll_rst   <= (w_state_nxt == S_PLL_RESET);
            sys_rst   <= (w_state_nxt != S_RUN);
            ready     <= (w_state_nxt == S_RUN);
            lock_lost <= w_lost_nxt;
            fault     <= (w_state_nxt == S_FAULT);
        end
    end

    assign retry_cnt = r_retry;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Testbench for pll_lock_supervisor: directed scenarios plus random
// lock activity, checked every cycle against a timestamp-based model.
module tb_pll_lock_supervisor;

    localparam int SYNC  = 2;
    localparam int T_RST = 4;
    localparam int T_TO  = 32;
    localparam int T_ST  = 8;
    localparam int NRET  = 2;

    localparam int P_RST   = 0;
    localparam int P_WAIT  = 1;
    localparam int P_STAB  = 2;
    localparam int P_RUN   = 3;
    localparam int P_FAULT = 4;

    logic       refclk;
    logic       rst;
    logic       pll_locked;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic       lock_lost;
    logic       fault;
    logic [1:0] retry_cnt;

    int checks   = 0;
    int failures = 0;

    // Model: phase, entry timestamp, retries used, lock-lost flag,
    // and the delayed lock samples seen by the supervisor.
    int   cyc     = 0;
    int   m_phase = P_RST;
    int   m_t0    = 0;
    int   m_ret   = 0;
    logic m_lost  = 1'b0;
    logic m_sq[$];

    pll_lock_supervisor #(
        .SYNC_STAGES        (SYNC),
        .PLL_RST_CYCLES     (T_RST),
        .LOCK_TIMEOUT_CYCLES(T_TO),
        .LOCK_STABLE_CYCLES (T_ST),
        .MAX_RETRIES        (NRET),
        .CNT_W              (16),
        .RETRY_W            (2)
    ) dut (
        .refclk    (refclk),
        .rst       (rst),
        .pll_locked(pll_locked),
        .pll_rst   (pll_rst),
        .sys_rst   (sys_rst),
        .ready     (ready),
        .lock_lost (lock_lost),
        .fault     (fault),
        .retry_cnt (retry_cnt)
    );

    initial refclk = 1'b0;
    always #10 refclk = ~refclk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic r;
        logic pl;
        logic ls;
        int   el;
        int   np;
        r  = rst;
        pl = pll_locked;
        @(posedge refclk);
        cyc++;
        ls = m_sq[SYNC-1];
        if (r) begin
            m_phase = P_RST;
            m_t0    = cyc;
            m_ret   = 0;
            m_lost  = 1'b0;
            m_sq    = '{1'b0, 1'b0};
        end else begin
            el     = cyc - 1 - m_t0;
            np     = m_phase;
            m_lost = 1'b0;
            case (m_phase)
                P_RST: if (el == T_RST - 1) np = P_WAIT;
                P_WAIT: begin
                    if (ls) np = P_STAB;
                    else if (el == T_TO - 1) begin
                        if (m_ret == NRET) np = P_FAULT;
                        else begin
                            m_ret++;
                            np = P_RST;
                        end
                    end
                end
                P_STAB: begin
                    if (!ls) np = P_WAIT;
                    else if (el == T_ST - 1) begin
                        np    = P_RUN;
                        m_ret = 0;
                    end
                end
                P_RUN: begin
                    if (!ls) begin
                        np     = P_RST;
                        m_lost = 1'b1;
                    end
                end
                default: ;
            endcase
            if (np != m_phase) begin
                m_phase = np;
                m_t0    = cyc;
            end
            m_sq.push_front(pl);
            void'(m_sq.pop_back());
        end
        #1;
        chk("m_pll_rst", pll_rst, m_phase == P_RST);
        chk("m_sys_rst", sys_rst, m_phase != P_RUN);
        chk("m_ready", ready, m_phase == P_RUN);
        chk("m_lock_lost", lock_lost, m_lost);
        chk("m_fault", fault, m_phase == P_FAULT);
        chk("m_retry", retry_cnt, m_ret);
    endtask

    function automatic logic sig(input int w);
        case (w)
            0:       return ready;
            1:       return !pll_rst;
            2:       return pll_rst;
            default: return fault;
        endcase
    endfunction

    // Steps until the selected condition holds or the bound expires.
    task automatic wait_until(input string tag, input int w,
                              input int bound, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!sig(w) && n < bound);
        chk({tag, "_reached"}, sig(w), 1'b1);
    endtask

    initial begin
        int n;
        int rises;
        logic prev;
        int run_left;
        m_sq       = '{1'b0, 1'b0};
        rst        = 1'b1;
        pll_locked = 1'b0;
        repeat (3) step();
        chk("rst_pll_rst", pll_rst, 1'b1);
        chk("rst_sys_rst", sys_rst, 1'b1);
        chk("rst_ready", ready, 1'b0);
        chk("rst_retry", retry_cnt, 2'd0);

        // Clean start
        rst = 1'b0;
        wait_until("s1_pllrst", 1, 50, n);
        chk("s1_pllrst_len", n, T_RST);
        repeat (10 - T_RST) step();
        pll_locked = 1'b1;
        wait_until("s1_ready", 0, 100, n);
        chk("s1_latency", n, 11);
        chk("s1_sys_rst", sys_rst, 1'b0);
        chk("s1_retry", retry_cnt, 2'd0);
        chk("s1_fault", fault, 1'b0);

        // Lock loss in RUN
        pll_locked = 1'b0;
        repeat (2) step();
        chk("s5_ready_hold", ready, 1'b1);
        step();
        chk("s5_lost", lock_lost, 1'b1);
        chk("s5_ready", ready, 1'b0);
        chk("s5_pll_rst", pll_rst, 1'b1);
        wait_until("s5_pllrst", 1, 50, n);
        chk("s5_pllrst_len", n, T_RST);
        pll_locked = 1'b1;
        wait_until("s5_relock", 0, 100, n);
        chk("s5_relock_lat", n, 11);

        // Reset while running
        rst = 1'b1;
        step();
        chk("s6r_pll_rst", pll_rst, 1'b1);
        chk("s6r_sys_rst", sys_rst, 1'b1);
        chk("s6r_ready", ready, 1'b0);
        chk("s6r_retry", retry_cnt, 2'd0);
        rst = 1'b0;
        wait_until("s6r_ready", 0, 100, n);
        chk("s6r_lat", n, 13);

        // Glitch in WAIT_LOCK, then a retry and a lock
        pll_locked = 1'b0;
        rst        = 1'b1;
        step();
        rst = 1'b0;
        wait_until("s2_wait", 1, 50, n);
        pll_locked = 1'b1;
        repeat (5) step();
        chk("s2_sys_rst", sys_rst, 1'b1);
        pll_locked = 1'b0;
        wait_until("s2_timeout", 2, 100, n);
        chk("s2_timeout_at", n, 35);
        chk("s3_retry1", retry_cnt, 2'd1);
        wait_until("s3_pllrst", 1, 50, n);
        chk("s3_pllrst_len", n, T_RST);
        pll_locked = 1'b1;
        wait_until("s3_ready", 0, 100, n);
        chk("s3_lat", n, 11);
        chk("s3_retry0", retry_cnt, 2'd0);

        // Reset while stabilising
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (8) step();
        chk("s6s_in_stab", sys_rst, 1'b1);
        rst = 1'b1;
        step();
        chk("s6s_pll_rst", pll_rst, 1'b1);
        chk("s6s_ready", ready, 1'b0);
        chk("s6s_retry", retry_cnt, 2'd0);
        rst = 1'b0;
        wait_until("s6s_ready", 0, 100, n);
        chk("s6s_lat", n, 13);

        // Fault after all retries
        pll_locked = 1'b0;
        rst        = 1'b1;
        step();
        rst   = 1'b0;
        n     = 0;
        rises = 0;
        prev  = pll_rst;
        do begin
            step();
            n++;
            if (pll_rst && !prev) rises++;
            prev = pll_rst;
        end while (!fault && n < 400);
        chk("s4_fault_at", n, 3 * (T_RST + T_TO));
        chk("s4_pulses", rises + 1, 3);
        chk("s4_retry", retry_cnt, 2'd2);
        chk("s4_pll_rst", pll_rst, 1'b0);
        chk("s4_sys_rst", sys_rst, 1'b1);
        repeat (200) step();
        chk("s4_sticky", fault, 1'b1);
        rst = 1'b1;
        step();
        chk("s4_cleared", fault, 1'b0);
        rst = 1'b0;

        // Random lock activity with occasional resets
        run_left = 0;
        for (int i = 0; i < 3000; i++) begin
            if (run_left == 0) begin
                pll_locked = 1'($urandom_range(0, 1));
                run_left   = $urandom_range(1, 40);
            end
            run_left--;
            rst = ($urandom_range(0, 299) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pll_lock_supervisor.md
Name: pll_lock_supervisor

Overview:
Supervises the system PLL and generates the design's reset sequencing from its lock indication. Runs on the free-running 50 MHz reference clock, which also feeds the PLL. Drives the PLL reset and retries on lock timeout. Holds the system reset until lock has been stable for a programmable time, and reports lock loss and hard fault. sys_rst is consumed downstream by the per-domain reset synchronisers in the 5 MHz output-clock domain.

Parameters:
SYNC_STAGES, 2, flops in the pll_locked synchroniser (>=2)
PLL_RST_CYCLES, 16, refclk cycles pll_rst is held high per reset pulse (>=1)
LOCK_TIMEOUT_CYCLES, 50000, cycles allowed in WAIT_LOCK before a retry (1 ms at 50 MHz)
LOCK_STABLE_CYCLES, 1000, consecutive locked cycles required before release (20 us)
MAX_RETRIES, 3, PLL reset retries after the initial attempt before FAULT
CNT_W, 16, shared counter width; must hold max(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES)
RETRY_W, 2, retry_cnt width; must hold MAX_RETRIES

Ports:
refclk  in  1  50 MHz reference clock; the only clock
rst  in  1  synchronous, active-high reset
pll_locked  in  1  PLL lock flag; asynchronous, may glitch
pll_rst  out  1  reset to the PLL, active-high
sys_rst  out  1  system reset request, active-high
ready  out  1  high while in RUN
lock_lost  out  1  one-cycle pulse when lock drops in RUN
fault  out  1  sticky; PLL failed to lock after all retries
retry_cnt  out  RETRY_W  retries consumed in the current acquisition

Behaviour:
- Interface: one clock (refclk); reset rst is synchronous and active-high.
- pll_locked passes through a SYNC_STAGES flop chain; the chain output is locked_s. Only locked_s is used. The chain is cleared to 0 by rst.
- All outputs are registered and decoded from the next state, so they change on the same edge as the state.
- While rst=1, the block holds state=PLL_RESET, cnt=0, retry_cnt=0, pll_rst=1, sys_rst=1, ready=0, lock_lost=0, fault=0.
- PLL_RESET:
  - Outputs: pll_rst=1, sys_rst=1.
  - cnt increments each cycle.
  - At cnt==PLL_RST_CYCLES-1, go to WAIT_LOCK with cnt=0.
  - pll_rst is therefore high for exactly PLL_RST_CYCLES cycles after rst is released, or after entry.
- WAIT_LOCK:
  - Outputs: pll_rst=0, sys_rst=1.
  - locked_s=1: go to STABILIZE with cnt=0. Lock takes priority over timeout in the same cycle.
  - Otherwise, at cnt==LOCK_TIMEOUT_CYCLES-1:
    - retry_cnt==MAX_RETRIES: go to FAULT.
    - Otherwise: retry_cnt+1, go to PLL_RESET with cnt=0.
- STABILIZE:
  - Outputs: pll_rst=0, sys_rst=1.
  - locked_s=0: go to WAIT_LOCK with cnt=0. The timeout restarts and retry_cnt is unchanged.
  - Otherwise cnt increments. At cnt==LOCK_STABLE_CYCLES-1 with locked_s=1, go to RUN with retry_cnt=0.
- RUN:
  - Outputs: sys_rst=0, ready=1.
  - locked_s=0: go to PLL_RESET with cnt=0. On that edge, lock_lost=1 for one cycle, sys_rst=1 and ready=0.
  - Lock loss does not consume a retry.
- FAULT:
  - Outputs: pll_rst=0, sys_rst=1, fault=1, ready=0.
  - Terminal; only rst exits.
- Latency, pll_locked rising to ready rising: SYNC_STAGES + 1 + LOCK_STABLE_CYCLES refclk edges, provided lock holds.
- Glitch filtering: a locked_s pulse shorter than LOCK_STABLE_CYCLES never releases sys_rst.
- Counter rules:
  - cnt saturates; it never wraps.
  - cnt is cleared on every state change.
- rst asserted mid-operation: on the next edge, everything returns to the reset values above, including from FAULT and RUN.
- lock_lost and ready are never high in the same cycle.
- sys_rst == ~ready in every cycle.

Test Plan:
All scenarios use SYNC_STAGES=2, PLL_RST_CYCLES=4, LOCK_TIMEOUT_CYCLES=32, LOCK_STABLE_CYCLES=8, MAX_RETRIES=2.
1. Clean start: release rst, raise pll_locked 10 cycles later and hold -> pll_rst high exactly 4 cycles after rst release; ready rises 11 edges after pll_locked rises; sys_rst falls on that same edge; retry_cnt=0; fault=0.
2. Glitch: in WAIT_LOCK, pulse pll_locked for 5 cycles, then low -> STABILIZE is entered and exited; sys_rst stays 1; no retry is consumed; timeout restarts from 0.
3. Retry then lock: keep pll_locked low for one full timeout -> retry_cnt=1 and a second 4-cycle pll_rst pulse; then lock and hold -> ready=1 and retry_cnt returns to 0 on RUN entry.
4. Fault: pll_locked never rises -> three pll_rst pulses total; retry_cnt=2; after the third timeout fault=1, sys_rst=1 and pll_rst=0, holding 200 further cycles; asserting rst clears fault.
5. Lock loss: in RUN, drop pll_locked -> 3 edges later lock_lost pulses for exactly one cycle, ready=0, sys_rst=1, pll_rst=1 for 4 cycles; relock reaches RUN again.
6. Mid-run reset: assert rst for one cycle in STABILIZE and in RUN -> next edge shows pll_rst=1, sys_rst=1, ready=0, retry_cnt=0, and the full sequence restarts.
